// File: rtl/bomb_tick_engine_if.sv
// Bomb tick engine bus: map snapshots and player positions in,
// committed maps, flames, hit flags and status out.
interface bomb_tick_engine_if;
    logic        tick;
    logic [99:0] arena_in;
    logic [99:0] bomb_bit0_in;
    logic [99:0] bomb_bit1_in;
    logic [3:0]  playerAx;
    logic [3:0]  playerAy;
    logic [3:0]  playerBx;
    logic [3:0]  playerBy;
    logic [99:0] arena_out;
    logic [99:0] bomb_bit0_out;
    logic [99:0] bomb_bit1_out;
    logic [99:0] flame_out;
    logic        playerA_hit;
    logic        playerB_hit;
    logic        busy;
    logic        done;
    logic        overrun;

    modport master (
        output tick, arena_in, bomb_bit0_in, bomb_bit1_in,
               playerAx, playerAy, playerBx, playerBy,
        input  arena_out, bomb_bit0_out, bomb_bit1_out, flame_out,
               playerA_hit, playerB_hit, busy, done, overrun
    );

    modport slave (
        input  tick, arena_in, bomb_bit0_in, bomb_bit1_in,
               playerAx, playerAy, playerBx, playerBy,
        output arena_out, bomb_bit0_out, bomb_bit1_out, flame_out,
               playerA_hit, playerB_hit, busy, done, overrun
    );
endinterface

// File: rtl/bomb_tick_engine.sv
// Bomb tick engine: on each tick, scans the 10x10 grid one cell per cycle,
// ages bomb timers, detonates expiring bombs with cross-shaped flames
// (one flame step per cycle), then commits maps, flames and hit flags.
module bomb_tick_engine #(
    parameter int RANGE = 2
) (
    input  logic              clk,
    input  logic              rst,
    bomb_tick_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, RAY, COMMIT} state_t;

    localparam logic [3:0] RNG = 4'(RANGE);

    state_t      state, state_nx;
    logic [99:0] w_arena, w_b0, w_b1, w_flame;
    logic [6:0]  idx;
    logic [3:0]  cx, cy;       // row/column of idx, tracked to avoid a divider
    logic [1:0]  dir;          // 0 up, 1 down, 2 left, 3 right
    logic [3:0]  step;

    logic [1:0]  cur_t;
    logic        explode, last_cell;
    logic [5:0]  tx, ty;       // unsigned; underflow wraps far above 9
    logic        in_range, tgt_border, tgt_wall, ray_stop;
    logic [6:0]  tidx;

    function automatic logic hit_at(input logic [99:0] f, input logic [3:0] x,
                                    input logic [3:0] y);
        logic [6:0] i;
        i = 7'(x) * 7'd10 + 7'(y);
        if (x > 4'd9 || y > 4'd9) return 1'b0;
        return f[i];
    endfunction

    // Current scan cell and ray target decode
    always_comb begin
        cur_t     = {w_b1[idx], w_b0[idx]};
        explode   = (cur_t == 2'd1);
        last_cell = (idx == 7'd99);
        tx        = {2'b00, cx};
        ty        = {2'b00, cy};
        case (dir)
            2'd0:    tx = {2'b00, cx} - {2'b00, step};
            2'd1:    tx = {2'b00, cx} + {2'b00, step};
            2'd2:    ty = {2'b00, cy} - {2'b00, step};
            default: ty = {2'b00, cy} + {2'b00, step};
        endcase
        in_range   = (tx <= 6'd9) && (ty <= 6'd9);
        tidx       = 7'(tx[3:0]) * 7'd10 + 7'(ty[3:0]);
        tgt_border = (tx == 6'd0) || (tx == 6'd9) || (ty == 6'd0) || (ty == 6'd9);
        tgt_wall   = in_range && w_arena[tidx];
        ray_stop   = !in_range || tgt_wall || (step == RNG);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (bus.tick) state_nx = SCAN;
            SCAN:   if (explode) state_nx = RAY;
                    else if (last_cell) state_nx = COMMIT;
            RAY:    if (ray_stop && dir == 2'd3) state_nx = last_cell ? COMMIT : SCAN;
            default: state_nx = IDLE;
        endcase
    end

    // Working maps, scan/ray counters and committed outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_arena           <= '0;
            w_b0              <= '0;
            w_b1              <= '0;
            w_flame           <= '0;
            idx               <= '0;
            cx                <= '0;
            cy                <= '0;
            dir               <= '0;
            step              <= '0;
            bus.arena_out     <= '0;
            bus.bomb_bit0_out <= '0;
            bus.bomb_bit1_out <= '0;
            bus.flame_out     <= '0;
            bus.playerA_hit   <= 1'b0;
            bus.playerB_hit   <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.overrun       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            // COMMIT counts as busy, so a tick there is an overrun too
            if (bus.tick && state != IDLE) bus.overrun <= 1'b1;
            case (state)
                IDLE: if (bus.tick) begin
                    w_arena  <= bus.arena_in;
                    w_b0     <= bus.bomb_bit0_in;
                    w_b1     <= bus.bomb_bit1_in;
                    w_flame  <= '0;
                    idx      <= '0;
                    cx       <= '0;
                    cy       <= '0;
                    bus.busy <= 1'b1;
                end
                SCAN: begin
                    case (cur_t)
                        2'd1: begin
                            w_b0[idx]    <= 1'b0;
                            w_flame[idx] <= 1'b1;
                            dir          <= 2'd0;
                            step         <= 4'd1;
                        end
                        2'd2: begin w_b1[idx] <= 1'b0; w_b0[idx] <= 1'b1; end
                        2'd3: w_b0[idx] <= 1'b0;
                        default: ;
                    endcase
                    if (!explode) begin
                        idx <= idx + 7'd1;
                        if (cy == 4'd9) begin cy <= '0; cx <= cx + 4'd1; end
                        else cy <= cy + 4'd1;
                    end
                end
                RAY: begin
                    // Border walls stop the ray unburnt; interior walls burn and stop it
                    if (in_range && !(tgt_wall && tgt_border)) w_flame[tidx] <= 1'b1;
                    if (tgt_wall && !tgt_border) w_arena[tidx] <= 1'b0;
                    else if (in_range && !tgt_wall && (w_b0[tidx] || w_b1[tidx])) begin
                        w_b0[tidx] <= 1'b1;
                        w_b1[tidx] <= 1'b0;
                    end
                    if (ray_stop) begin
                        step <= 4'd1;
                        if (dir == 2'd3) begin
                            idx <= idx + 7'd1;
                            if (cy == 4'd9) begin cy <= '0; cx <= cx + 4'd1; end
                            else cy <= cy + 4'd1;
                        end else begin
                            dir <= dir + 2'd1;
                        end
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                default: begin
                    bus.arena_out     <= w_arena;
                    bus.bomb_bit0_out <= w_b0;
                    bus.bomb_bit1_out <= w_b1;
                    bus.flame_out     <= w_flame;
                    bus.playerA_hit   <= hit_at(w_flame, bus.playerAx, bus.playerAy);
                    bus.playerB_hit   <= hit_at(w_flame, bus.playerBx, bus.playerBy);
                    bus.done          <= 1'b1;
                    bus.busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bomb_tick_engine.sv
// Directed bench for bomb_tick_engine (RANGE=2): each pass pushes its
// expected commit into a scoreboard queue, which is popped at done.
module tb_bomb_tick_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bomb_tick_engine_if bus();
    bomb_tick_engine #(.RANGE(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [99:0] arena, b0, b1, flame;
        logic        ha, hb;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          npass = 0;
    int          ntot  = 0;
    logic [99:0] ea, e0, e1, ef;
    logic        eha, ehb;
    int          elat;

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic set_in(input logic [99:0] a, input logic [99:0] b0, input logic [99:0] b1,
                          input logic [3:0] ax, input logic [3:0] ay,
                          input logic [3:0] bx, input logic [3:0] by);
        bus.arena_in     = a;
        bus.bomb_bit0_in = b0;
        bus.bomb_bit1_in = b1;
        bus.playerAx = ax; bus.playerAy = ay;
        bus.playerBx = bx; bus.playerBy = by;
    endtask

    task automatic set_exp(input int lat, input logic ha, input logic hb);
        ea = '0; e0 = '0; e1 = '0; ef = '0;
        elat = lat; eha = ha; ehb = hb;
    endtask

    // Push expectation, pulse tick, wait for done (bounded), pop and compare.
    task automatic run_pass(input string tag, input int ovr_at);
        exp_t e;
        int   lat;
        bit   seen;
        sb.push_back('{ea, e0, e1, ef, eha, ehb, elat});
        @(negedge clk); bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        chk({tag, "_busy_start"}, 100'(bus.busy), 100'(1));
        lat = 0; seen = 0;
        while (!seen && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (ovr_at > 0) bus.tick = (lat == ovr_at);
            if (bus.done) seen = 1;
        end
        bus.tick = 1'b0;
        e = sb.pop_front();
        chk({tag, "_done_seen"}, 100'(seen), 100'(1));
        chk({tag, "_latency"},   100'(lat), 100'(e.lat));
        chk({tag, "_arena"},     bus.arena_out, e.arena);
        chk({tag, "_bit0"},      bus.bomb_bit0_out, e.b0);
        chk({tag, "_bit1"},      bus.bomb_bit1_out, e.b1);
        chk({tag, "_flame"},     bus.flame_out, e.flame);
        chk({tag, "_hitA"},      100'(bus.playerA_hit), 100'(e.ha));
        chk({tag, "_hitB"},      100'(bus.playerB_hit), 100'(e.hb));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 100'(bus.done), 100'(0));
        chk({tag, "_busy_end"},   100'(bus.busy), 100'(0));
    endtask

    initial begin
        logic [99:0] a, b0, b1;
        bit          seen;
        bus.tick = 1'b0;
        set_in('0, '0, '0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_arena",   bus.arena_out, '0);
        chk("rst_bit0",    bus.bomb_bit0_out, '0);
        chk("rst_bit1",    bus.bomb_bit1_out, '0);
        chk("rst_flame",   bus.flame_out, '0);
        chk("rst_busy",    100'(bus.busy), 100'(0));
        chk("rst_done",    100'(bus.done), 100'(0));
        chk("rst_overrun", 100'(bus.overrun), 100'(0));
        chk("rst_hitA",    100'(bus.playerA_hit), 100'(0));
        rst = 1'b1;

        // Fresh bomb at 44 just ages to 2
        b0 = '0; b1 = '0; b0[44] = 1'b1; b1[44] = 1'b1;
        set_in('0, b0, b1, 4'd4, 4'd4, 4'd15, 4'd15);
        set_exp(101, 1'b0, 1'b0);
        e1[44] = 1'b1;
        run_pass("age", 0);

        // Open field detonation at 55; B off-grid never hits
        b0 = '0; b1 = '0; b0[55] = 1'b1;
        set_in('0, b0, b1, 4'd3, 4'd5, 4'd10, 4'd5);
        set_exp(109, 1'b1, 1'b0);
        ef[35] = 1; ef[45] = 1; ef[55] = 1; ef[65] = 1; ef[75] = 1;
        ef[53] = 1; ef[54] = 1; ef[56] = 1; ef[57] = 1;
        run_pass("open", 0);

        // Interior wall at 45 burns and stops the up ray
        a = '0; a[45] = 1'b1; a[59] = 1'b1;
        set_in(a, b0, '0, 4'd5, 4'd6, 4'd0, 4'd0);
        set_exp(108, 1'b1, 1'b0);
        ea[59] = 1'b1;
        ef[55] = 1; ef[45] = 1; ef[65] = 1; ef[75] = 1;
        ef[54] = 1; ef[53] = 1; ef[56] = 1; ef[57] = 1;
        run_pass("wall", 0);

        // Border walls stop rays without burning
        a = '0;
        for (int i = 0; i < 10; i++) begin
            a[i] = 1'b1; a[90+i] = 1'b1; a[i*10] = 1'b1; a[i*10+9] = 1'b1;
        end
        b0 = '0; b0[11] = 1'b1;
        set_in(a, b0, '0, 4'd0, 4'd1, 4'd1, 4'd3);
        set_exp(107, 1'b0, 1'b1);
        ea = a;
        ef[11] = 1; ef[21] = 1; ef[31] = 1; ef[12] = 1; ef[13] = 1;
        run_pass("border", 0);

        // Chain: 24 (> 22) fires same pass, 21 (< 22) is left at timer 1
        b0 = '0; b1 = '0;
        b0[22] = 1'b1;
        b0[24] = 1'b1; b1[24] = 1'b1;
        b0[21] = 1'b1; b1[21] = 1'b1;
        set_in('0, b0, b1, 4'd2, 4'd6, 4'd9, 4'd9);
        set_exp(117, 1'b1, 1'b0);
        e0[21] = 1'b1;
        ef[2] = 1; ef[12] = 1; ef[22] = 1; ef[32] = 1; ef[42] = 1;
        ef[20] = 1; ef[21] = 1; ef[23] = 1; ef[24] = 1;
        ef[4] = 1; ef[14] = 1; ef[34] = 1; ef[44] = 1; ef[25] = 1; ef[26] = 1;
        run_pass("chain1", 0);

        // Next tick detonates 21; left ray runs off the grid at step 2
        b0 = '0; b0[21] = 1'b1;
        set_in('0, b0, '0, 4'd2, 4'd6, 4'd0, 4'd1);
        set_exp(109, 1'b0, 1'b1);
        ef[21] = 1; ef[11] = 1; ef[1] = 1; ef[31] = 1; ef[41] = 1;
        ef[20] = 1; ef[22] = 1; ef[23] = 1;
        run_pass("chain2", 0);

        // Reset mid-pass aborts with no commit
        @(negedge clk); bus.tick = 1'b1;
        @(posedge clk); #1 bus.tick = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("midrst_flame", bus.flame_out, '0);
        chk("midrst_bit0",  bus.bomb_bit0_out, '0);
        chk("midrst_busy",  100'(bus.busy), 100'(0));
        chk("midrst_hitB",  100'(bus.playerB_hit), 100'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1;
        end
        chk("midrst_quiet", 100'(seen), 100'(0));

        set_in('0, '0, '0, 4'd0, 4'd0, 4'd0, 4'd0);
        set_exp(101, 1'b0, 1'b0);
        run_pass("postrst", 0);
        chk("postrst_overrun", 100'(bus.overrun), 100'(0));

        // Tick while busy sets a sticky overrun
        set_exp(101, 1'b0, 1'b0);
        run_pass("ovr", 50);
        chk("ovr_set", 100'(bus.overrun), 100'(1));
        set_exp(101, 1'b0, 1'b0);
        run_pass("ovr_hold", 0);
        chk("ovr_sticky", 100'(bus.overrun), 100'(1));
        @(negedge clk); rst = 1'b0;
        #1;
        chk("ovr_cleared", 100'(bus.overrun), 100'(0));
        @(negedge clk); rst = 1'b1;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/bomb_tick_engine.md
Name: bomb_tick_engine

Overview:
- Sits directly downstream of the character-control stage. Consumes its per-cell arena and 2-bit bomb-timer maps.
- On each bomb tick it ages every bomb, detonates expiring bombs, and propagates cross-shaped flames that destroy interior walls and chain-trigger other bombs.
- It then commits the updated maps, a flame map and player-hit flags for the arena/display logic.
- Grid is 10x10, cell index = x*10+y (x row, y column).

Parameters:
- RANGE, 2, flame reach in cells per direction (1..9).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- tick  in  1  one-cycle pulse; starts one bomb-aging pass.
- arena_in  in  100  wall map, 1 = wall.
- bomb_bit0_in  in  100  bomb timer bit 0 per cell.
- bomb_bit1_in  in  100  bomb timer bit 1 per cell.
- playerAx, playerAy, playerBx, playerBy  in  4 each  player coordinates.
- arena_out  out  100  committed wall map.
- bomb_bit0_out  out  100  committed bomb timer bit 0.
- bomb_bit1_out  out  100  committed bomb timer bit 1.
- flame_out  out  100  cells burning after the last pass.
- playerA_hit, playerB_hit  out  1 each  player stands on a flame cell at commit.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at commit.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Timer encoding: 0 = empty, 3 = freshly placed, 2 and 1 = counting, 1 = expires on the next pass.
- Border cells (x or y equal to 0 or 9) are indestructible. Interior walls are destructible.
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0: arena_out, bomb bits, flame_out, hits, busy, done, overrun.
  - A reset mid-pass aborts the pass; no partial commit.
- IDLE:
  - tick=1 at edge E0 snapshots arena_in/bomb_in into working registers.
  - Working flame map cleared, idx=0, busy=1, state -> SCAN.
  - tick=0 leaves all outputs held.
- SCAN, one cell per edge:
  - Cell timer 1: set timer to 0, mark flame at the cell, enter RAY with dir=up, step=1.
  - Cell timer 2 or 3: decrement.
  - Cell timer 0: no change.
  - No explosion: idx++; after idx=99 -> COMMIT.
- RAY, one step per edge:
  - Direction order: up (x-1), down (x+1), left (y-1), right (y+1).
  - Target = centre + dir*step.
  - Target outside 0..9: ray ends, no mark.
  - Target is a border wall: ray ends, no mark.
  - Target is an interior wall: clear the wall, mark flame, ray ends.
  - Otherwise: mark flame. If the target timer is nonzero, set it to 1 (chain). Continue.
  - Ray also ends after step=RANGE.
  - Ray end: next dir, step=1. After the right ray ends -> SCAN at idx+1, or COMMIT if idx=99.
  - Every step consumes one edge, including the terminating step.
- Chain ordering:
  - A chained bomb with index > idx detonates in the same pass.
  - A chained bomb with index <= idx detonates on the next tick.
  - Bombs decremented to 1 in this pass wait for the next tick.
- COMMIT, one edge:
  - Outputs load from the working registers.
  - playerA_hit/playerB_hit = flame at (x*10+y). Coordinates >9 never hit.
  - done=1 for this cycle, busy=0, state -> IDLE.
  - Outputs then hold until the next commit.
- Latency:
  - No explosions: done is high in the cycle after edge E0+101.
  - Each explosion adds the number of ray cycles it consumes, at most 4*RANGE.
- Flame marking is idempotent; overlapping flames are marked once.
- A tick while busy is ignored and sets overrun. Only reset clears overrun.
- tick coincident with the COMMIT edge is treated as busy, so overrun is set.

Test Plan:
- Reset with rst=0 mid-pass, then release -> all outputs 0, busy=0, no done pulse until the next tick plus 101 edges.
- Empty arena, bomb timer 3 at index 44, tick -> done at E0+101; index 44 timer = 2; flame_out = 0.
- Open field, timer 1 at (5,5), RANGE=2, tick -> flame at indices 35, 45, 55, 65, 75, 53, 54, 56, 57 only; timer 55 = 0; done at E0+109.
- Timer 1 at (5,5), interior wall at (4,5), border wall at (5,9), playerA=(5,6) -> wall 45 cleared, no flame at 35, playerA_hit=1, playerB_hit=0.
- Chain test: timer 1 at (2,2), timer 3 at (2,4) (index 24 > 22), timer 3 at (2,1) -> 24 detonates same pass (flame reaches 26); 21 committed with timer 1; the next tick detonates 21.
- Second tick asserted 50 cycles after the first -> ignored, overrun=1 and stays 1 through later passes until rst=0.
